// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared types and constants for the conv -> maxpool -> dense frame sequencer.
package cnn_layer_sequencer_pkg;

  localparam int unsigned DEFAULT_NUM_STAGES = 3;

  localparam int unsigned STG_CONV  = 0;
  localparam int unsigned STG_POOL  = 1;
  localparam int unsigned STG_DENSE = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } seq_state_e;

  // States in which a frame is in flight; drives o_busy and the cycle counter.
  function automatic logic is_active(input seq_state_e s);
    return (s == S_CLEAR) || (s == S_RUN) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_stage_watchdog.sv
// Per-stage watchdog: counts enabled cycles and flags the terminal count.
module cnn_layer_sequencer_stage_watchdog
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_tc;

  assign w_tc = (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign o_tc = w_tc;

  // Holds at terminal count so it never wraps if the caller ignores o_tc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame-level controller: clears all stages, then enables each stage in turn until it reports done.
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = DEFAULT_NUM_STAGES,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [NUM_STAGES-1:0]         i_stage_done,
  output logic [NUM_STAGES-1:0]         o_stage_en,
  output logic [NUM_STAGES-1:0]         o_stage_clr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [$clog2(NUM_STAGES)-1:0] o_err_stage,
  output logic [CNT_W-1:0]              o_cycle_count
);

  localparam int unsigned IDX_W = $clog2(NUM_STAGES);

  seq_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_k, w_k_nxt;
  logic [IDX_W-1:0] r_err_stage, w_err_stage_nxt;
  logic             r_error, w_error_nxt;
  logic             r_abort, w_abort_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic w_done_k;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_tc;

  // Only the active stage's done bit is ever looked at.
  assign w_done_k = i_stage_done[r_k];
  assign w_wd_clr = (r_state != S_RUN) || w_done_k;
  assign w_wd_en  = (r_state == S_RUN);

  cnn_layer_sequencer_stage_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_wd_clr),
    .i_en  (w_wd_en),
    .o_tc  (w_wd_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_err_stage <= '0;
      r_error     <= 1'b0;
      r_abort     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_err_stage <= w_err_stage_nxt;
      r_error     <= w_error_nxt;
      r_abort     <= w_abort_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_err_stage_nxt = r_err_stage;
    w_error_nxt     = r_error;
    w_abort_nxt     = r_abort;
    w_cnt_nxt       = r_cnt;
    if (is_active(r_state) && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
          w_error_nxt = 1'b0;
          w_k_nxt     = '0;
          w_abort_nxt = 1'b0;
        end
      end
      S_CLEAR: begin
        // r_abort marks a clear pulse issued on the way out of an aborted frame.
        if (i_abort || r_abort) begin
          w_state_nxt = S_IDLE;
          w_abort_nxt = 1'b0;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_CLEAR;
          w_abort_nxt = 1'b1;
        end else if (w_done_k) begin
          if (r_k == IDX_W'(NUM_STAGES - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_k_nxt = r_k + IDX_W'(1);
          end
        end else if (w_wd_tc) begin
          w_state_nxt     = S_ERROR;
          w_error_nxt     = 1'b1;
          w_err_stage_nxt = r_k;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
          w_error_nxt = 1'b0;
          w_k_nxt     = '0;
          w_abort_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_stage_en  = '0;
    o_stage_clr = '0;
    if (r_state == S_RUN) begin
      o_stage_en[r_k] = 1'b1;
    end
    if (r_state == S_CLEAR) begin
      o_stage_clr = '1;
    end
  end

  assign o_busy        = is_active(r_state);
  assign o_done        = (r_state == S_DONE);
  assign o_error       = r_error;
  assign o_err_stage   = r_err_stage;
  assign o_cycle_count = r_cnt;

endmodule
